// File: rtl/seven_segment_arbiter.sv
// Round-robin arbiter that shares one 4-digit seven-segment display between four
// requesters, holding each owner for a minimum dwell time before preemption.
module seven_segment_arbiter #(
  parameter  int unsigned DWELL_CYCLES = 100_000_000,
  localparam int unsigned CNT_BITS     = $clog2(DWELL_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [63:0] reqData,
  input  logic [15:0] reqDigitDisplay,
  input  logic [15:0] reqDigitPoint,
  output logic [3:0]  grant,
  output logic [1:0]  owner,
  output logic        busy,
  output logic [15:0] dataOut,
  output logic [3:0]  digitDisplayOut,
  output logic [3:0]  digitPointOut
);

  localparam logic [CNT_BITS-1:0] DWELL_MAX = CNT_BITS'(DWELL_CYCLES);

  typedef enum logic {
    ST_IDLE,
    ST_OWN
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic [1:0]          ptr_q,   ptr_d;
  logic [CNT_BITS-1:0] cnt_q,   cnt_d;
  logic [3:0]          grant_q, grant_d;
  logic [15:0]         data_q,  data_d;
  logic [3:0]          disp_q,  disp_d;
  logic [3:0]          point_q, point_d;
  logic [1:0]          pick;
  logic                take;

  // First requester after the last owner, wrapping round to the last owner itself.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] res;
    logic [1:0] idx;
    res = p;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = idx;
    end
    return res;
  endfunction

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = 4'b0000;
    data_d  = 16'h0000;
    disp_d  = 4'h0;
    point_d = 4'h0;
    pick    = rr_pick(req, ptr_q);
    take    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (|req) take = 1'b1;
      end
      ST_OWN: begin
        if (!req[owner_q]) begin
          if (|req) take = 1'b1;
          else      state_d = ST_IDLE;
        end else if ((cnt_q == DWELL_MAX) && (|(req & ~grant_q))) begin
          take = 1'b1;
        end else if (cnt_q != DWELL_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take) begin
      state_d = ST_OWN;
      owner_d = pick;
      ptr_d   = pick;
      cnt_d   = '0;
    end

    // Outputs track the slice of whoever owns the display after this edge.
    if (state_d == ST_OWN) begin
      grant_d = 4'b0001 << owner_d;
      data_d  = reqData[16*owner_d +: 16];
      disp_d  = reqDigitDisplay[4*owner_d +: 4];
      point_d = reqDigitPoint[4*owner_d +: 4];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
      grant_q <= 4'b0000;
      data_q  <= 16'h0000;
      disp_q  <= 4'h0;
      point_q <= 4'h0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      disp_q  <= disp_d;
      point_q <= point_d;
    end
  end

  assign grant           = grant_q;
  assign busy            = |grant_q;
  assign owner           = owner_q;
  assign dataOut         = data_q;
  assign digitDisplayOut = disp_q;
  assign digitPointOut   = point_q;

endmodule
